sym_game_ctrl: RTL and testbench

//  Round sequencer for the symbol-counter game. Sits between the player input logic and the

---
 rtl/sym_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sym_game_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sym_game_ctrl.sv
// Round sequencer for the symbol-counter game: gates the symbol generator, paces it per level,
// scores presses against special symbols and tracks score, level and lives.
module sym_game_ctrl #(
  parameter int unsigned START_MAX  = 100_000_000,
  parameter int unsigned MIN_MAX    = 10_000_000,
  parameter int unsigned STEP       = 5_000_000,
  parameter int unsigned ROUND_SYMS = 16,
  parameter int unsigned WINDOW     = 50_000_000,
  parameter int unsigned COUNTDOWN  = 200_000_000,
  parameter int unsigned LIVES      = 3
) (
  input  logic        Clk100M,
  input  logic        rst_n,
  input  logic        start,
  input  logic        press,
  input  logic        generated,
  input  logic        special,
  output logic        genSym,
  output logic [31:0] symGenMax,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [3:0]  level,
  output logic [1:0]  lives,
  output logic        hit,
  output logic        miss,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Pacing is floored at MIN_MAX; compare in 33 bits so the subtraction never wraps.
  localparam logic [32:0] FLOOR_SUM = 33'(MIN_MAX) + 33'(STEP);

  state_t      state_q, state_d;
  logic [31:0] cd_q, cd_d;
  logic [31:0] sym_q, sym_d;
  logic [31:0] win_q, win_d;
  logic        armed_q, armed_d;
  logic        gen_d, over_d, hit_d, miss_d;
  logic [31:0] max_d;
  logic [15:0] score_d;
  logic [3:0]  level_d;
  logic [1:0]  lives_d;
  logic        begin_game, hit_ev, expire, arm_new, lose;

  assign state = state_q;

  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cd_q      <= '0;
      sym_q     <= '0;
      win_q     <= '0;
      armed_q   <= 1'b0;
      genSym    <= 1'b0;
      symGenMax <= 32'(START_MAX);
      score     <= '0;
      level     <= '0;
      lives     <= 2'(LIVES);
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      sym_q     <= sym_d;
      win_q     <= win_d;
      armed_q   <= armed_d;
      genSym    <= gen_d;
      symGenMax <= max_d;
      score     <= score_d;
      level     <= level_d;
      lives     <= lives_d;
      hit       <= hit_d;
      miss      <= miss_d;
      game_over <= over_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cd_d       = cd_q;
    sym_d      = sym_q;
    win_d      = win_q;
    armed_d    = armed_q;
    max_d      = symGenMax;
    score_d    = score;
    level_d    = level;
    lives_d    = lives;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    begin_game = 1'b0;
    hit_ev     = 1'b0;
    expire     = 1'b0;
    arm_new    = 1'b0;
    lose       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin_game = 1'b1;
      end
      S_READY: begin
        if (cd_q == '0) state_d = S_PLAY;
        else            cd_d    = cd_q - 32'd1;
      end
      S_PLAY: begin
        // The press is judged against the window as it stood before this cycle's symbol.
        arm_new = generated & special;
        hit_ev  = press & armed_q;
        expire  = armed_q & ~press & (win_q == '0);
        lose    = (press & ~armed_q) | expire | (armed_q & ~press & arm_new);

        if (arm_new) begin
          armed_d = 1'b1;
          win_d   = 32'(WINDOW - 1);
        end else if (hit_ev || expire) begin
          armed_d = 1'b0;
          win_d   = '0;
        end else if (armed_q) begin
          win_d = win_q - 32'd1;
        end

        if (hit_ev && score != 16'hFFFF) score_d = score + 16'd1;
        hit_d = hit_ev;

        if (generated) begin
          if (sym_q == 32'(ROUND_SYMS - 1)) begin
            sym_d = '0;
            if (level != 4'd15) level_d = level + 4'd1;
            if ({1'b0, symGenMax} < FLOOR_SUM) max_d = 32'(MIN_MAX);
            else                               max_d = symGenMax - 32'(STEP);
          end else begin
            sym_d = sym_q + 32'd1;
          end
        end

        if (lose) begin
          miss_d = 1'b1;
          if (lives <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives - 2'd1;
          end
        end
      end
      S_OVER: begin
        if (start) begin_game = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_game) begin
      state_d = S_READY;
      cd_d    = 32'(COUNTDOWN - 1);
      score_d = '0;
      level_d = '0;
      lives_d = 2'(LIVES);
      max_d   = 32'(START_MAX);
      sym_d   = '0;
      win_d   = '0;
      armed_d = 1'b0;
    end

    gen_d  = (state_d == S_PLAY);
    over_d = (state_d == S_OVER);
  end

endmodule

// File: tb/tb_sym_game_ctrl.sv
// Directed bench for sym_game_ctrl: a vector table walks a full game and a restart, and a few
// hand sequences cover asynchronous reset and overlapping special windows.
module tb_sym_game_ctrl;

  typedef struct {
    logic [3:0]  stim;
    logic [31:0] e_state, e_gen, e_hit, e_miss, e_score, e_lives, e_level, e_max, e_over;
  } vec_t;

  logic        Clk100M = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, press = 1'b0, generated = 1'b0, special = 1'b0;
  logic        genSym, hit, miss, game_over;
  logic [31:0] symGenMax;
  logic [1:0]  state, lives;
  logic [15:0] score;
  logic [3:0]  level;

  int total = 0;
  int bad = 0;
  vec_t vq[$];

  sym_game_ctrl #(
    .START_MAX(8), .MIN_MAX(2), .STEP(3), .ROUND_SYMS(4),
    .WINDOW(5), .COUNTDOWN(3), .LIVES(3)
  ) dut (
    .Clk100M(Clk100M), .rst_n(rst_n), .start(start), .press(press),
    .generated(generated), .special(special), .genSym(genSym), .symGenMax(symGenMax),
    .state(state), .score(score), .level(level), .lives(lives),
    .hit(hit), .miss(miss), .game_over(game_over)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic row(input logic [3:0] stim, input int s, g, h, m, sc, lv, lev, mx, ov);
    vec_t v;
    v.stim = stim;
    v.e_state = s; v.e_gen = g; v.e_hit = h; v.e_miss = m; v.e_score = sc;
    v.e_lives = lv; v.e_level = lev; v.e_max = mx; v.e_over = ov;
    vq.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge and are held for exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] stim);
    {start, press, generated, special} = stim;
    @(posedge Clk100M);
    @(negedge Clk100M);
    {start, press, generated, special} = 4'b0000;
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, " state"}, 32'(state), v.e_state);
    checkOutput({tag, " genSym"}, 32'(genSym), v.e_gen);
    checkOutput({tag, " hit"}, 32'(hit), v.e_hit);
    checkOutput({tag, " miss"}, 32'(miss), v.e_miss);
    checkOutput({tag, " score"}, 32'(score), v.e_score);
    checkOutput({tag, " lives"}, 32'(lives), v.e_lives);
    checkOutput({tag, " level"}, 32'(level), v.e_level);
    checkOutput({tag, " symGenMax"}, symGenMax, v.e_max);
    checkOutput({tag, " game_over"}, 32'(game_over), v.e_over);
  endtask

  task automatic resetPulse();
    @(negedge Clk100M);
    #2 rst_n = 1'b0;
    @(negedge Clk100M);
    rst_n = 1'b1;
  endtask

  task automatic waitForPlay(input string tag);
    for (int k = 0; k < 20 && state != 2'd2; k++) applyStimulus(4'b0000);
    checkOutput({tag, " reach play"}, 32'(state), 32'd2);
  endtask

  initial begin
    vec_t rv;
    // stim = {start, press, generated, special}
    //  stim     st g h m sc lv lev max ov
    row(4'b1000, 1, 0, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 1, 0, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 1, 0, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 2, 1, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0011, 2, 1, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 2, 1, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0100, 2, 1, 1, 0, 1, 3, 0, 8, 0);
    row(4'b0100, 2, 1, 0, 1, 1, 2, 0, 8, 0);
    row(4'b0010, 2, 1, 0, 0, 1, 2, 0, 8, 0);
    row(4'b0010, 2, 1, 0, 0, 1, 2, 0, 8, 0);
    row(4'b0010, 2, 1, 0, 0, 1, 2, 1, 5, 0);
    for (int i = 0; i < 3; i++) row(4'b0010, 2, 1, 0, 0, 1, 2, 1, 5, 0);
    row(4'b0010, 2, 1, 0, 0, 1, 2, 2, 2, 0);
    for (int i = 0; i < 3; i++) row(4'b0010, 2, 1, 0, 0, 1, 2, 2, 2, 0);
    row(4'b0010, 2, 1, 0, 0, 1, 2, 3, 2, 0);
    row(4'b1000, 2, 1, 0, 0, 1, 2, 3, 2, 0);
    row(4'b0011, 2, 1, 0, 0, 1, 2, 3, 2, 0);
    for (int i = 0; i < 4; i++) row(4'b0000, 2, 1, 0, 0, 1, 2, 3, 2, 0);
    row(4'b0000, 2, 1, 0, 1, 1, 1, 3, 2, 0);
    row(4'b0100, 3, 0, 0, 1, 1, 0, 3, 2, 1);
    row(4'b0111, 3, 0, 0, 0, 1, 0, 3, 2, 1);
    row(4'b1000, 1, 0, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 1, 0, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 1, 0, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0000, 2, 1, 0, 0, 0, 3, 0, 8, 0);
    row(4'b0111, 2, 1, 0, 1, 0, 2, 0, 8, 0);
    row(4'b0100, 2, 1, 1, 0, 1, 2, 0, 8, 0);

    resetPulse();
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset genSym", 32'(genSym), 32'd0);
    checkOutput("reset symGenMax", symGenMax, 32'd8);
    checkOutput("reset lives", 32'(lives), 32'd3);
    checkOutput("reset game_over", 32'(game_over), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].stim);
      checkAll($sformatf("row%0d", i), vq[i]);
    end

    // Asynchronous reset in the middle of play must clear everything without a clock edge.
    @(negedge Clk100M);
    #2 rst_n = 1'b0;
    #1;
    rv.stim = 4'b0000;
    rv.e_state = 0; rv.e_gen = 0; rv.e_hit = 0; rv.e_miss = 0; rv.e_score = 0;
    rv.e_lives = 3; rv.e_level = 0; rv.e_max = 8; rv.e_over = 0;
    checkAll("async reset", rv);
    @(negedge Clk100M);
    rst_n = 1'b1;

    // A new special while a window is still open and unpressed costs that window a life.
    applyStimulus(4'b1000);
    waitForPlay("overlap");
    applyStimulus(4'b0011);
    checkOutput("overlap first miss", 32'(miss), 32'd0);
    applyStimulus(4'b0011);
    checkOutput("overlap miss", 32'(miss), 32'd1);
    checkOutput("overlap lives", 32'(lives), 32'd2);
    applyStimulus(4'b0100);
    checkOutput("overlap hit", 32'(hit), 32'd1);
    checkOutput("overlap score", 32'(score), 32'd1);
    checkOutput("overlap lives kept", 32'(lives), 32'd2);
    applyStimulus(4'b0000);
    checkOutput("hit pulse width", 32'(hit), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
